input_port_requester: RTL
=========================

// Module: input_port_requester
// PURPOSE
//  Requester end of the router arbitration protocol, one instance per input port (N/S/W/E/L).
//  - Buffers incoming flits and computes the XY next hop of the head flit.
//  - Drives nexthop_addr_o to every output-port round-robin processor, then waits for that port's grant.
//  - On grant, issues the flit to the crossbar and pulses change_order_o so the granting arbiter rotates its order.
// PARAMETERS
//  FLIT_W       32  flit width; header bits [FLIT_W-1 -: X_W] = dest X, next Y_W bits = dest Y
//  DEPTH        4   input FIFO entries; power of 2, >=2
//  X_W          2   X coordinate width
//  Y_W          2   Y coordinate width
//  MY_X         0   this router's X coordinate
//  MY_Y         0   this router's Y coordinate
//  TIMEOUT_CYC  15  starvation threshold in cycles (used only with IPR_TIMEOUT_EN)
// PORTS
//  clk             in   1       clock, rising edge
//  reset           in   1       asynchronous, active-low reset
//  flit_i          in   FLIT_W  incoming flit from link/local
//  flit_valid_i    in   1       flit_i valid; pushed when flit_valid_i && flit_ready_o
//  flit_ready_o    out  1       FIFO not full (combinational from count)
//  nexthop_addr_o  out  3       requested output port: N=000 S=001 W=010 E=011 L=100 NONE=111
//  grant_n_i       in   1       grant from N rr processor
//  grant_s_i       in   1       grant from S rr processor
//  grant_w_i       in   1       grant from W rr processor
//  grant_e_i       in   1       grant from E rr processor
//  grant_l_i       in   1       grant from L rr processor
//  flit_o          out  FLIT_W  head flit to crossbar
//  flit_valid_o    out  1       flit_o valid; one cycle per granted flit
//  change_order_o  out  1       one-cycle pulse, coincident with flit_valid_o
//  starve_o        out  1       request pending >= TIMEOUT_CYC cycles (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0, async):
//  - FIFO empty, state IDLE, nexthop_addr_o=NONE; flit_valid_o, change_order_o, starve_o = 0; flit_o = 0.
//  - flit_ready_o=1 (reset released).
//  FIFO: count 0..DEPTH; rd/wr pointers wrap mod DEPTH.
//  - Push and pop in the same cycle: both occur, count unchanged (including when full).
//  - Upstream pushing while flit_ready_o=0 is a protocol violation; the flit is dropped and the bench asserts on it.
//  Route (xy_route_calc, combinational on the head flit):
//  - dx>MY_X -> E; dx<MY_X -> W; else dy>MY_Y -> N; dy<MY_Y -> S; else L.
//  FSM (states IDLE, REQ, XFER):
//  - IDLE: if count>0 at the clock edge, register the head route into nexthop_addr_o -> REQ; else hold NONE.
//  - REQ: nexthop_addr_o stable. Only the grant matching nexthop_addr_o is honoured; others are ignored. Matching grant -> XFER.
//  - XFER (exactly 1 cycle): flit_o=head, flit_valid_o=1, change_order_o=1, pop head.
//    - Next state: REQ if the post-pop count (including a same-cycle push) is >0, with the new head's route registered; else IDLE.
//    - nexthop_addr_o=NONE during XFER.
//  - Latency: empty FIFO, push at cycle 0 -> nexthop_addr_o valid at cycle 2. Grant seen at edge k -> flit_valid_o at cycle k+1.
//  - Back-to-back throughput: 1 flit per 2 cycles when grants are immediate.
//  - Reset asserted mid-operation: all state cleared immediately. No partial flit_valid_o or change_order_o is emitted.
// CONFIGURATION
//  IPR_TIMEOUT_EN defined:
//  - 5-bit wait counter increments each REQ cycle, saturates at TIMEOUT_CYC, clears on XFER or reset.
//  - starve_o=1 while counter==TIMEOUT_CYC.
//  IPR_TIMEOUT_EN undefined: no counter; starve_o tied 0.
// STRUCTURE
//  - noc_pkg:
//    - dir_t enum (N=000, S=001, W=010, E=011, L=100, NONE=111)
//    - ipr_state_t enum {IDLE, REQ, XFER}
//    - header field offset constants
//  - One sub-module: xy_route_calc (dest X/Y, MY_X/MY_Y -> dir_t).
//  - FIFO and FSM stay inline.
// TESTING
//  1. Reset with flit_valid_i=1 -> nexthop_addr_o=111, flit_ready_o=1, no push until reset=1.
//  2. MY=(1,1); push dest (3,1), grant_e_i=1 at REQ -> nexthop=011; flit_valid_o and change_order_o one cycle later; FIFO empty.
//  3. Push dest (1,1); assert grant_n_i only for 3 cycles, then grant_l_i -> nexthop=100 held; no transfer until grant_l_i.
//  4. Fill 4 flits -> flit_ready_o=0. Grant + push on the same cycle -> count stays 4; order preserved; routes follow each head.
//  5. Assert reset during XFER -> flit_valid_o=0 and change_order_o=0 immediately; FIFO empty after release.
//  6. IPR_TIMEOUT_EN defined, TIMEOUT_CYC=15, no grant -> starve_o=1 after 15 REQ cycles; 0 the cycle after the grant.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router types: output-port direction codes, requester FSM states and header field offsets.
package noc_pkg;

    typedef enum logic [2:0] {
        DIR_N    = 3'b000,
        DIR_S    = 3'b001,
        DIR_W    = 3'b010,
        DIR_E    = 3'b011,
        DIR_L    = 3'b100,
        DIR_NONE = 3'b111
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } ipr_state_t;

    localparam int WAIT_CNT_W = 5;

    // Destination X sits in the top bits of the header, destination Y directly below it.
    function automatic int hdr_x_msb(input int flit_w);
        return flit_w - 1;
    endfunction

    function automatic int hdr_y_msb(input int flit_w, input int x_w);
        return flit_w - 1 - x_w;
    endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Dimension-ordered (X first, then Y) next-hop selection for a flit destination.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int X_W  = 2,
    parameter int Y_W  = 2,
    parameter int MY_X = 0,
    parameter int MY_Y = 0
) (
    input  logic [X_W-1:0] dest_x,
    input  logic [Y_W-1:0] dest_y,
    output dir_t           dir
);

    localparam logic [X_W-1:0] MY_X_V = X_W'(MY_X);
    localparam logic [Y_W-1:0] MY_Y_V = Y_W'(MY_Y);

    always_comb begin
        if (dest_x > MY_X_V) begin
            dir = DIR_E;
        end else if (dest_x < MY_X_V) begin
            dir = DIR_W;
        end else if (dest_y > MY_Y_V) begin
            dir = DIR_N;
        end else if (dest_y < MY_Y_V) begin
            dir = DIR_S;
        end else begin
            dir = DIR_L;
        end
    end

endmodule

// File: rtl/input_port_requester.sv
// Input-port requester: flit FIFO, XY next-hop request, grant wait and crossbar issue.
// Optional starvation counter enabled by defining IPR_TIMEOUT_EN.
module input_port_requester
    import noc_pkg::*;
#(
    parameter int FLIT_W      = 32,
    parameter int DEPTH       = 4,
    parameter int X_W         = 2,
    parameter int Y_W         = 2,
    parameter int MY_X        = 0,
    parameter int MY_Y        = 0,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              flit_valid_i,
    output logic              flit_ready_o,
    output logic [2:0]        nexthop_addr_o,
    input  logic              grant_n_i,
    input  logic              grant_s_i,
    input  logic              grant_w_i,
    input  logic              grant_e_i,
    input  logic              grant_l_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              flit_valid_o,
    output logic              change_order_o,
    output logic              starve_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int X_MSB = hdr_x_msb(FLIT_W);
    localparam int Y_MSB = hdr_y_msb(FLIT_W, X_W);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    ipr_state_t        state_reg;
    dir_t              nexthop_reg;
    logic [FLIT_W-1:0] flit_reg;
    logic              flit_valid_reg;
    logic              change_order_reg;

    logic              push, pop, grant_match;
    logic [FLIT_W-1:0] head;
    logic [X_W-1:0]    route_x;
    logic [Y_W-1:0]    route_y;
    dir_t              route_dir;

    // A slot being popped this cycle can be refilled, so a full FIFO still accepts during XFER.
    assign flit_ready_o = (count_reg != FULL_CNT) || (state_reg == XFER);
    assign push         = flit_valid_i && flit_ready_o;
    assign pop          = (state_reg == XFER);
    assign count_next   = count_reg + CNT_W'(push) - CNT_W'(pop);
    assign head         = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= flit_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // During XFER the route is needed for the flit that becomes head after the pop,
    // which is the bypassed input flit when the FIFO is about to drain.
    always_comb begin
        route_x = head[X_MSB -: X_W];
        route_y = head[Y_MSB -: Y_W];
        if (state_reg == XFER) begin
            if (count_reg > CNT_W'(1)) begin
                route_x = mem[rd_ptr_reg + PTR_W'(1)][X_MSB -: X_W];
                route_y = mem[rd_ptr_reg + PTR_W'(1)][Y_MSB -: Y_W];
            end else begin
                route_x = flit_i[X_MSB -: X_W];
                route_y = flit_i[Y_MSB -: Y_W];
            end
        end
    end

    xy_route_calc #(
        .X_W  (X_W),
        .Y_W  (Y_W),
        .MY_X (MY_X),
        .MY_Y (MY_Y)
    ) u_route (
        .dest_x (route_x),
        .dest_y (route_y),
        .dir    (route_dir)
    );

    always_comb begin
        grant_match = 1'b0;
        case (nexthop_reg)
            DIR_N:   grant_match = grant_n_i;
            DIR_S:   grant_match = grant_s_i;
            DIR_W:   grant_match = grant_w_i;
            DIR_E:   grant_match = grant_e_i;
            DIR_L:   grant_match = grant_l_i;
            default: grant_match = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            nexthop_reg      <= DIR_NONE;
            flit_reg         <= '0;
            flit_valid_reg   <= 1'b0;
            change_order_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (count_reg != '0) begin
                        nexthop_reg <= route_dir;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    if (grant_match) begin
                        state_reg        <= XFER;
                        nexthop_reg      <= DIR_NONE;
                        flit_reg         <= head;
                        flit_valid_reg   <= 1'b1;
                        change_order_reg <= 1'b1;
                    end
                end
                XFER: begin
                    flit_valid_reg   <= 1'b0;
                    change_order_reg <= 1'b0;
                    if (count_next != '0) begin
                        nexthop_reg <= route_dir;
                        state_reg   <= REQ;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    nexthop_reg <= DIR_NONE;
                end
            endcase
        end
    end

    assign nexthop_addr_o = nexthop_reg;
    assign flit_o         = flit_reg;
    assign flit_valid_o   = flit_valid_reg;
    assign change_order_o = change_order_reg;

`ifdef IPR_TIMEOUT_EN
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(TIMEOUT_CYC);
    logic [WAIT_CNT_W-1:0] wait_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == REQ && !grant_match) begin
            if (wait_cnt_reg != TIMEOUT_VAL) begin
                wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_W'(1);
            end
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign starve_o = (wait_cnt_reg == TIMEOUT_VAL);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign starve_o       = 1'b0;
`endif

endmodule
